// File: rtl/axi_2x2_pkg.sv
// Shared constants for the 2x2 AXI-Lite crossbar: routing encodings,
// outstanding-counter sizing and the OKAY response code.
package axi_2x2_pkg;
    localparam logic       SEL_STRAIGHT = 1'b0;
    localparam logic       SEL_CROSS    = 1'b1;
    localparam int         CNT_W        = 4;
    localparam logic [1:0] OKAY         = 2'b00;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
endpackage

// File: rtl/axi_2x2_txn_cnt.sv
// Outstanding-transaction tracker for one subordinate port of the 2x2
// crossbar. Holds saturating write (AW vs B) and read (AR vs R) counts and
// reports whether the port will be quiet after the current edge.
module axi_2x2_txn_cnt
    import axi_2x2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic aw_hs,
    input  logic b_hs,
    input  logic ar_hs,
    input  logic r_hs,
    input  logic awvalid,
    input  logic wvalid,
    input  logic arvalid,
    output logic idle
);
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] n;
        n = c;
        if (inc && !dec && (c != CNT_MAX)) begin
            n = c + CNT_ONE;
        end else if (dec && !inc && (c != CNT_ZERO)) begin
            n = c - CNT_ONE;
        end else begin
            n = c;
        end
        return n;
    endfunction

    // Next-count computation and idle flag (idle looks at the post-edge counts).
    always_comb begin
        wr_cnt_d = cnt_step(wr_cnt_q, aw_hs, b_hs);
        rd_cnt_d = cnt_step(rd_cnt_q, ar_hs, r_hs);
        idle     = (wr_cnt_d == CNT_ZERO) && (rd_cnt_d == CNT_ZERO) &&
                   !awvalid && !wvalid && !arvalid;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= CNT_ZERO;
            rd_cnt_q <= CNT_ZERO;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
endmodule

// File: rtl/axi_2x2_switch.sv
// Registered-select 2x2 crossbar for single-beat AXI-Lite buses.
// sel=0 routes in0<->out0 / in1<->out1, sel=1 swaps them; each rising edge
// with switch_sel high inverts sel. Datapath is pure combinational passthrough.
// Optional build macro AXI_2X2_SAFE_SWITCH_EN: a switch request is held pending,
// new AW/W/AR are blocked, and sel only flips once both out ports are idle.
module axi_2x2_switch
    import axi_2x2_pkg::*;
#(
    parameter  int AXI_ADDR_WIDTH = 20,
    parameter  int AXI_DATA_WIDTH = 16,
    localparam int STRB_W         = (AXI_DATA_WIDTH + 7) / 8
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst_n,
    input  logic                      switch_sel,
    output logic                      sel,
    input  logic [AXI_ADDR_WIDTH-1:0] in0_axi_awaddr, in1_axi_awaddr,
    input  logic                      in0_axi_awvalid, in1_axi_awvalid,
    input  logic [AXI_DATA_WIDTH-1:0] in0_axi_wdata, in1_axi_wdata,
    input  logic [STRB_W-1:0]         in0_axi_wstrb, in1_axi_wstrb,
    input  logic                      in0_axi_wvalid, in1_axi_wvalid,
    input  logic                      in0_axi_bready, in1_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] in0_axi_araddr, in1_axi_araddr,
    input  logic                      in0_axi_arvalid, in1_axi_arvalid,
    input  logic                      in0_axi_rready, in1_axi_rready,
    output logic                      in0_axi_awready, in1_axi_awready,
    output logic                      in0_axi_wready, in1_axi_wready,
    output logic [1:0]                in0_axi_bresp, in1_axi_bresp,
    output logic                      in0_axi_bvalid, in1_axi_bvalid,
    output logic                      in0_axi_arready, in1_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] in0_axi_rdata, in1_axi_rdata,
    output logic [1:0]                in0_axi_rresp, in1_axi_rresp,
    output logic                      in0_axi_rvalid, in1_axi_rvalid,
    output logic [AXI_ADDR_WIDTH-1:0] out0_axi_awaddr, out1_axi_awaddr,
    output logic                      out0_axi_awvalid, out1_axi_awvalid,
    output logic [AXI_DATA_WIDTH-1:0] out0_axi_wdata, out1_axi_wdata,
    output logic [STRB_W-1:0]         out0_axi_wstrb, out1_axi_wstrb,
    output logic                      out0_axi_wvalid, out1_axi_wvalid,
    output logic                      out0_axi_bready, out1_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] out0_axi_araddr, out1_axi_araddr,
    output logic                      out0_axi_arvalid, out1_axi_arvalid,
    output logic                      out0_axi_rready, out1_axi_rready,
    input  logic                      out0_axi_awready, out1_axi_awready,
    input  logic                      out0_axi_wready, out1_axi_wready,
    input  logic [1:0]                out0_axi_bresp, out1_axi_bresp,
    input  logic                      out0_axi_bvalid, out1_axi_bvalid,
    input  logic                      out0_axi_arready, out1_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] out0_axi_rdata, out1_axi_rdata,
    input  logic [1:0]                out0_axi_rresp, out1_axi_rresp,
    input  logic                      out0_axi_rvalid, out1_axi_rvalid
);
    logic sel_q, sel_d;
    logic x_s;     // crossed routing active
    logic gate_s;  // request valids / readies blocked while a switch waits

    assign x_s = (sel_q == SEL_CROSS);
    assign sel = sel_q;

    // Request path: each out port carries its mapped in port's fields.
    assign out0_axi_awaddr  = x_s ? in1_axi_awaddr : in0_axi_awaddr;
    assign out1_axi_awaddr  = x_s ? in0_axi_awaddr : in1_axi_awaddr;
    assign out0_axi_awvalid = ~gate_s & (x_s ? in1_axi_awvalid : in0_axi_awvalid);
    assign out1_axi_awvalid = ~gate_s & (x_s ? in0_axi_awvalid : in1_axi_awvalid);
    assign out0_axi_wdata   = x_s ? in1_axi_wdata : in0_axi_wdata;
    assign out1_axi_wdata   = x_s ? in0_axi_wdata : in1_axi_wdata;
    assign out0_axi_wstrb   = x_s ? in1_axi_wstrb : in0_axi_wstrb;
    assign out1_axi_wstrb   = x_s ? in0_axi_wstrb : in1_axi_wstrb;
    assign out0_axi_wvalid  = ~gate_s & (x_s ? in1_axi_wvalid : in0_axi_wvalid);
    assign out1_axi_wvalid  = ~gate_s & (x_s ? in0_axi_wvalid : in1_axi_wvalid);
    assign out0_axi_bready  = x_s ? in1_axi_bready : in0_axi_bready;
    assign out1_axi_bready  = x_s ? in0_axi_bready : in1_axi_bready;
    assign out0_axi_araddr  = x_s ? in1_axi_araddr : in0_axi_araddr;
    assign out1_axi_araddr  = x_s ? in0_axi_araddr : in1_axi_araddr;
    assign out0_axi_arvalid = ~gate_s & (x_s ? in1_axi_arvalid : in0_axi_arvalid);
    assign out1_axi_arvalid = ~gate_s & (x_s ? in0_axi_arvalid : in1_axi_arvalid);
    assign out0_axi_rready  = x_s ? in1_axi_rready : in0_axi_rready;
    assign out1_axi_rready  = x_s ? in0_axi_rready : in1_axi_rready;

    // Response path: each in port sees its mapped out port's fields.
    assign in0_axi_awready = ~gate_s & (x_s ? out1_axi_awready : out0_axi_awready);
    assign in1_axi_awready = ~gate_s & (x_s ? out0_axi_awready : out1_axi_awready);
    assign in0_axi_wready  = ~gate_s & (x_s ? out1_axi_wready : out0_axi_wready);
    assign in1_axi_wready  = ~gate_s & (x_s ? out0_axi_wready : out1_axi_wready);
    assign in0_axi_bresp   = x_s ? out1_axi_bresp : out0_axi_bresp;
    assign in1_axi_bresp   = x_s ? out0_axi_bresp : out1_axi_bresp;
    assign in0_axi_bvalid  = x_s ? out1_axi_bvalid : out0_axi_bvalid;
    assign in1_axi_bvalid  = x_s ? out0_axi_bvalid : out1_axi_bvalid;
    assign in0_axi_arready = ~gate_s & (x_s ? out1_axi_arready : out0_axi_arready);
    assign in1_axi_arready = ~gate_s & (x_s ? out0_axi_arready : out1_axi_arready);
    assign in0_axi_rdata   = x_s ? out1_axi_rdata : out0_axi_rdata;
    assign in1_axi_rdata   = x_s ? out0_axi_rdata : out1_axi_rdata;
    assign in0_axi_rresp   = x_s ? out1_axi_rresp : out0_axi_rresp;
    assign in1_axi_rresp   = x_s ? out0_axi_rresp : out1_axi_rresp;
    assign in0_axi_rvalid  = x_s ? out1_axi_rvalid : out0_axi_rvalid;
    assign in1_axi_rvalid  = x_s ? out0_axi_rvalid : out1_axi_rvalid;

`ifdef AXI_2X2_SAFE_SWITCH_EN
    logic pend_q, pend_d;
    logic idle0_s, idle1_s;

    assign gate_s = pend_q;

    axi_2x2_txn_cnt u_cnt0 (
        .clk     (axi_clk),
        .rst_n   (axi_rst_n),
        .aw_hs   (out0_axi_awvalid & out0_axi_awready),
        .b_hs    (out0_axi_bvalid & out0_axi_bready),
        .ar_hs   (out0_axi_arvalid & out0_axi_arready),
        .r_hs    (out0_axi_rvalid & out0_axi_rready),
        .awvalid (out0_axi_awvalid),
        .wvalid  (out0_axi_wvalid),
        .arvalid (out0_axi_arvalid),
        .idle    (idle0_s)
    );

    axi_2x2_txn_cnt u_cnt1 (
        .clk     (axi_clk),
        .rst_n   (axi_rst_n),
        .aw_hs   (out1_axi_awvalid & out1_axi_awready),
        .b_hs    (out1_axi_bvalid & out1_axi_bready),
        .ar_hs   (out1_axi_arvalid & out1_axi_arready),
        .r_hs    (out1_axi_rvalid & out1_axi_rready),
        .awvalid (out1_axi_awvalid),
        .wvalid  (out1_axi_wvalid),
        .arvalid (out1_axi_arvalid),
        .idle    (idle1_s)
    );

    // Flip sel once both ports drain; otherwise remember the request.
    always_comb begin
        sel_d  = sel_q;
        pend_d = pend_q;
        if ((switch_sel || pend_q) && idle0_s && idle1_s) begin
            sel_d  = ~sel_q;
            pend_d = 1'b0;
        end else if (switch_sel) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Pending-switch register.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    assign gate_s = 1'b0;

    // Unconditional toggle on every sampled switch request.
    always_comb begin
        sel_d = sel_q;
        if (switch_sel) begin
            sel_d = ~sel_q;
        end else begin
            sel_d = sel_q;
        end
    end
`endif

    // Routing-select register.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            sel_q <= SEL_STRAIGHT;
        end else begin
            sel_q <= sel_d;
        end
    end
endmodule

// File: tb/tb_axi_2x2_switch.sv
// Self-checking bench for axi_2x2_switch: directed reset/toggle/write/read
// cases, randomized passthrough against an index-based routing model, and
// either the held-toggle case or (with AXI_2X2_SAFE_SWITCH_EN) the safe-switch case.
module tb_axi_2x2_switch;
    logic clk = 1'b0;
    logic rst_n;
    logic switch_sel;
    logic sel;

    // Manager side (index = in port number)
    logic [19:0] m_awaddr[2], m_araddr[2];
    logic [15:0] m_wdata[2], m_rdata[2];
    logic [1:0]  m_wstrb[2], m_bresp[2], m_rresp[2];
    logic        m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
    logic        m_awready[2], m_wready[2], m_bvalid[2], m_arready[2], m_rvalid[2];
    // Subordinate side (index = out port number)
    logic [19:0] s_awaddr[2], s_araddr[2];
    logic [15:0] s_wdata[2], s_rdata[2];
    logic [1:0]  s_wstrb[2], s_bresp[2], s_rresp[2];
    logic        s_awvalid[2], s_wvalid[2], s_bready[2], s_arvalid[2], s_rready[2];
    logic        s_awready[2], s_wready[2], s_bvalid[2], s_arready[2], s_rvalid[2];

    int n_chk  = 0;
    int n_pass = 0;
    logic msel = 1'b0;  // model of the routing select

    always #5 clk = ~clk;

    axi_2x2_switch dut (
        .axi_clk(clk), .axi_rst_n(rst_n), .switch_sel(switch_sel), .sel(sel),
        .in0_axi_awaddr(m_awaddr[0]), .in1_axi_awaddr(m_awaddr[1]),
        .in0_axi_awvalid(m_awvalid[0]), .in1_axi_awvalid(m_awvalid[1]),
        .in0_axi_wdata(m_wdata[0]), .in1_axi_wdata(m_wdata[1]),
        .in0_axi_wstrb(m_wstrb[0]), .in1_axi_wstrb(m_wstrb[1]),
        .in0_axi_wvalid(m_wvalid[0]), .in1_axi_wvalid(m_wvalid[1]),
        .in0_axi_bready(m_bready[0]), .in1_axi_bready(m_bready[1]),
        .in0_axi_araddr(m_araddr[0]), .in1_axi_araddr(m_araddr[1]),
        .in0_axi_arvalid(m_arvalid[0]), .in1_axi_arvalid(m_arvalid[1]),
        .in0_axi_rready(m_rready[0]), .in1_axi_rready(m_rready[1]),
        .in0_axi_awready(m_awready[0]), .in1_axi_awready(m_awready[1]),
        .in0_axi_wready(m_wready[0]), .in1_axi_wready(m_wready[1]),
        .in0_axi_bresp(m_bresp[0]), .in1_axi_bresp(m_bresp[1]),
        .in0_axi_bvalid(m_bvalid[0]), .in1_axi_bvalid(m_bvalid[1]),
        .in0_axi_arready(m_arready[0]), .in1_axi_arready(m_arready[1]),
        .in0_axi_rdata(m_rdata[0]), .in1_axi_rdata(m_rdata[1]),
        .in0_axi_rresp(m_rresp[0]), .in1_axi_rresp(m_rresp[1]),
        .in0_axi_rvalid(m_rvalid[0]), .in1_axi_rvalid(m_rvalid[1]),
        .out0_axi_awaddr(s_awaddr[0]), .out1_axi_awaddr(s_awaddr[1]),
        .out0_axi_awvalid(s_awvalid[0]), .out1_axi_awvalid(s_awvalid[1]),
        .out0_axi_wdata(s_wdata[0]), .out1_axi_wdata(s_wdata[1]),
        .out0_axi_wstrb(s_wstrb[0]), .out1_axi_wstrb(s_wstrb[1]),
        .out0_axi_wvalid(s_wvalid[0]), .out1_axi_wvalid(s_wvalid[1]),
        .out0_axi_bready(s_bready[0]), .out1_axi_bready(s_bready[1]),
        .out0_axi_araddr(s_araddr[0]), .out1_axi_araddr(s_araddr[1]),
        .out0_axi_arvalid(s_arvalid[0]), .out1_axi_arvalid(s_arvalid[1]),
        .out0_axi_rready(s_rready[0]), .out1_axi_rready(s_rready[1]),
        .out0_axi_awready(s_awready[0]), .out1_axi_awready(s_awready[1]),
        .out0_axi_wready(s_wready[0]), .out1_axi_wready(s_wready[1]),
        .out0_axi_bresp(s_bresp[0]), .out1_axi_bresp(s_bresp[1]),
        .out0_axi_bvalid(s_bvalid[0]), .out1_axi_bvalid(s_bvalid[1]),
        .out0_axi_arready(s_arready[0]), .out1_axi_arready(s_arready[1]),
        .out0_axi_rdata(s_rdata[0]), .out1_axi_rdata(s_rdata[1]),
        .out0_axi_rresp(s_rresp[0]), .out1_axi_rresp(s_rresp[1]),
        .out0_axi_rvalid(s_rvalid[0]), .out1_axi_rvalid(s_rvalid[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_inputs();
        switch_sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = 20'h0; m_awvalid[i] = 1'b0; m_wdata[i] = 16'h0;
            m_wstrb[i] = 2'b00; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
            m_araddr[i] = 20'h0; m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
            s_awready[i] = 1'b0; s_wready[i] = 1'b0; s_bresp[i] = 2'b00;
            s_bvalid[i] = 1'b0; s_arready[i] = 1'b0; s_rdata[i] = 16'h0;
            s_rresp[i] = 2'b00; s_rvalid[i] = 1'b0;
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = 20'($urandom); m_awvalid[i] = 1'($urandom);
            m_wdata[i] = 16'($urandom); m_wstrb[i] = 2'($urandom);
            m_wvalid[i] = 1'($urandom); m_bready[i] = 1'($urandom);
            m_araddr[i] = 20'($urandom); m_arvalid[i] = 1'($urandom);
            m_rready[i] = 1'($urandom);
            s_awready[i] = 1'($urandom); s_wready[i] = 1'($urandom);
            s_bresp[i] = 2'($urandom); s_bvalid[i] = 1'($urandom);
            s_arready[i] = 1'($urandom); s_rdata[i] = 16'($urandom);
            s_rresp[i] = 2'($urandom); s_rvalid[i] = 1'($urandom);
        end
    endtask

    // Routing model: in port n and out port n^msel are paired, in both directions.
    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int p;
            p = m ^ int'(msel);
            check("out_awaddr", s_awaddr[m], m_awaddr[p]);
            check("out_awvalid", s_awvalid[m], m_awvalid[p]);
            check("out_wdata", s_wdata[m], m_wdata[p]);
            check("out_wstrb", s_wstrb[m], m_wstrb[p]);
            check("out_wvalid", s_wvalid[m], m_wvalid[p]);
            check("out_bready", s_bready[m], m_bready[p]);
            check("out_araddr", s_araddr[m], m_araddr[p]);
            check("out_arvalid", s_arvalid[m], m_arvalid[p]);
            check("out_rready", s_rready[m], m_rready[p]);
            check("in_awready", m_awready[m], s_awready[p]);
            check("in_wready", m_wready[m], s_wready[p]);
            check("in_bresp", m_bresp[m], s_bresp[p]);
            check("in_bvalid", m_bvalid[m], s_bvalid[p]);
            check("in_arready", m_arready[m], s_arready[p]);
            check("in_rdata", m_rdata[m], s_rdata[p]);
            check("in_rresp", m_rresp[m], s_rresp[p]);
            check("in_rvalid", m_rvalid[m], s_rvalid[p]);
        end
    endtask

    // One rising edge; model flips when a switch request was sampled.
    task automatic tick();
        logic sw;
        sw = switch_sel;
        @(posedge clk);
        #1;
        if (sw) msel = ~msel;
        check("sel", sel, msel);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("sel_in_reset", sel, 1'b0);
        #1;
        rst_n = 1'b1;
        msel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("sel_reset", sel, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Reset: straight passthrough
        m_awaddr[0] = 20'h12345;
        m_awaddr[1] = 20'h54321;
        #1;
        check("rst_out0_awaddr", s_awaddr[0], 20'h12345);
        check("rst_out1_awaddr", s_awaddr[1], 20'h54321);
        check_all();

        // Toggle sequence: 1 -> hold -> 0
        @(negedge clk); clear_inputs(); switch_sel = 1'b1; tick();
        check("toggle_1", sel, 1'b1);
        @(negedge clk); switch_sel = 1'b0; tick();
        check("toggle_hold", sel, 1'b1);
        @(negedge clk); switch_sel = 1'b1; tick();
        check("toggle_0", sel, 1'b0);

        // Straight write, same-cycle passthrough
        @(negedge clk);
        clear_inputs();
        m_awaddr[0] = 20'h12345; m_awvalid[0] = 1'b1;
        m_wdata[0] = 16'hABCD; m_wstrb[0] = 2'b11; m_wvalid[0] = 1'b1;
        s_awready[0] = 1'b1; s_wready[0] = 1'b1;
        #1;
        check("wr_out0_awaddr", s_awaddr[0], 20'h12345);
        check("wr_out0_wdata", s_wdata[0], 16'hABCD);
        check("wr_out0_wstrb", s_wstrb[0], 2'b11);
        check("wr_in0_awready", m_awready[0], 1'b1);
        check("wr_in0_wready", m_wready[0], 1'b1);
        check_all();

        // Move to crossed, then crossed read
        @(negedge clk); clear_inputs(); switch_sel = 1'b1; tick();
        @(negedge clk);
        clear_inputs();
        m_araddr[0] = 20'h00F00; m_arvalid[0] = 1'b1; m_rready[0] = 1'b1;
        s_arready[1] = 1'b1; s_rvalid[1] = 1'b1; s_rdata[1] = 16'h5A5A;
        #1;
        check("rd_out1_araddr", s_araddr[1], 20'h00F00);
        check("rd_in0_rdata", m_rdata[0], 16'h5A5A);
        check("rd_out0_arvalid", s_arvalid[0], 1'b0);
        check("rd_in0_arready", m_arready[0], 1'b1);
        check_all();

        // Randomized passthrough
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            rand_inputs();
`ifdef AXI_2X2_SAFE_SWITCH_EN
            switch_sel = 1'b0;
`else
            switch_sel = ($urandom_range(0, 3) == 0);
`endif
            #1;
            check_all();
            tick();
        end

        reset_pulse();
`ifdef AXI_2X2_SAFE_SWITCH_EN
        // Safe switch: write outstanding on out0 delays the swap
        m_awvalid[0] = 1'b1; m_awaddr[0] = 20'h00ABC; s_awready[0] = 1'b1;
        @(posedge clk); #1;
        check("safe_aw_sel", sel, 1'b0);
        @(negedge clk);
        m_awvalid[0] = 1'b0; s_awready[0] = 1'b0; switch_sel = 1'b1;
        @(posedge clk); #1;
        check("safe_hold", sel, 1'b0);
        @(negedge clk);
        switch_sel = 1'b0; m_awvalid[0] = 1'b1; s_awready[0] = 1'b1;
        #1;
        check("safe_blk_awvalid", s_awvalid[0], 1'b0);
        check("safe_blk_awready", m_awready[0], 1'b0);
        @(posedge clk); #1;
        check("safe_still_0", sel, 1'b0);
        @(negedge clk);
        m_awvalid[0] = 1'b0; s_awready[0] = 1'b0;
        s_bvalid[0] = 1'b1; m_bready[0] = 1'b1;
        #1;
        check("safe_bvalid", m_bvalid[0], 1'b1);
        @(posedge clk); #1;
        check("safe_switched", sel, 1'b1);
        @(negedge clk); clear_inputs();
        msel = 1'b1;
`else
        // switch_sel held high for three edges
        switch_sel = 1'b1;
        tick(); check("held_1", sel, 1'b1);
        tick(); check("held_2", sel, 1'b0);
        tick(); check("held_3", sel, 1'b1);
        @(negedge clk); switch_sel = 1'b0; tick();
        check("held_release", sel, 1'b1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
